lm32_dtlb_ctrl: RTL and testbench

CSR-side control stage for the data TLB. It holds the TLB programming registers (virtual address, physical address, bad virtual address and control) and turns CSR writes into one-cycle update, invalidate and flush strobes for the DTLB. It consumes the DTLB miss indication, captures the faulting address, raises the miss exception and tracks flush-in-progress so the pipeline can stall.

---
 rtl/lm32_dtlb_ctrl_if.sv | 32 +++
 rtl/lm32_dtlb_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lm32_dtlb_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lm32_dtlb_ctrl_if.sv
// CSR, pipeline and DTLB-facing signals of the data TLB control stage.
// csr_write_enable is a one-cycle strobe with no ready; writes that arrive while busy are dropped and flagged.
interface lm32_dtlb_ctrl_if;
  logic [2:0]  csr_sel;
  logic        csr_write_enable;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;
  logic        miss_x;
  logic [31:0] address_x;
  logic        stall_x;
  logic [31:0] tlbvaddr;
  logic [31:0] tlbpaddr;
  logic        update;
  logic        invalidate;
  logic        flush;
  logic        dtlb_enable;
  logic        busy;
  logic        miss_exception;
  logic        fsm_state;

  modport master (
    output csr_sel, csr_write_enable, csr_write_data, miss_x, address_x, stall_x,
    input  csr_read_data, tlbvaddr, tlbpaddr, update, invalidate, flush,
           dtlb_enable, busy, miss_exception, fsm_state
  );

  modport slave (
    input  csr_sel, csr_write_enable, csr_write_data, miss_x, address_x, stall_x,
    output csr_read_data, tlbvaddr, tlbpaddr, update, invalidate, flush,
           dtlb_enable, busy, miss_exception, fsm_state
  );
endinterface

// File: rtl/lm32_dtlb_ctrl.sv
// Data TLB CSR control stage: programming registers, update/invalidate/flush strobes, miss capture.
// Optional saturating miss counter at TLBMISSCNT when LM32_DTLB_MISS_COUNTER_EN is defined.
module lm32_dtlb_ctrl #(
  parameter int entries   = 1024,
  parameter int page_size = 4096
) (
  input logic             clk_i,
  input logic             rst_i,
  lm32_dtlb_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE       = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

  localparam int              OFFSET_BITS = $clog2(page_size);
  localparam logic [31:0]     PAGE_MASK   = 32'hFFFF_FFFF << OFFSET_BITS;
  localparam int              CNT_W       = $clog2(entries + 1);
  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(entries);

  localparam logic [2:0] SEL_VADDR   = 3'd0;
  localparam logic [2:0] SEL_PADDR   = 3'd1;
  localparam logic [2:0] SEL_BADADDR = 3'd2;
  localparam logic [2:0] SEL_CTRL    = 3'd3;
  localparam logic [2:0] SEL_MISSCNT = 3'd4;

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;
  logic [31:0]      tlbvaddr_q;
  logic [31:0]      tlbpaddr_q;
  logic [31:0]      badvaddr_q;
  logic             update_q;
  logic             invalidate_q;
  logic             flush_q;
  logic             enable_q;
  logic             dropped_q;
  logic             miss_pending_q;
  logic             miss_exc_q;
  logic [31:0]      miss_cnt_rd;

  logic wr_accept;
  logic wr_drop;
  logic vaddr_wr;
  logic paddr_wr;
  logic ctrl_wr;
  logic cmd_flush;
  logic cmd_inval;
  logic miss_seen;
  logic miss_capture;

  assign wr_accept    = bus.csr_write_enable && (state == IDLE);
  assign wr_drop      = bus.csr_write_enable && (state == FLUSH_WAIT);
  assign vaddr_wr     = wr_accept && (bus.csr_sel == SEL_VADDR);
  assign paddr_wr     = wr_accept && (bus.csr_sel == SEL_PADDR);
  assign ctrl_wr      = wr_accept && (bus.csr_sel == SEL_CTRL);
  assign cmd_flush    = ctrl_wr && (bus.csr_write_data[1:0] == 2'd1);
  assign cmd_inval    = ctrl_wr && (bus.csr_write_data[1:0] == 2'd2);
  assign miss_seen    = bus.miss_x && !bus.stall_x;
  assign miss_capture = miss_seen && !miss_pending_q;

  // Reset lands in FLUSH_WAIT so the pipeline waits out the DTLB's own reset flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= FLUSH_WAIT;
      flush_cnt      <= CNT_INIT;
      tlbvaddr_q     <= '0;
      tlbpaddr_q     <= '0;
      badvaddr_q     <= '0;
      update_q       <= 1'b0;
      invalidate_q   <= 1'b0;
      flush_q        <= 1'b0;
      enable_q       <= 1'b0;
      dropped_q      <= 1'b0;
      miss_pending_q <= 1'b0;
      miss_exc_q     <= 1'b0;
    end else begin
      update_q     <= paddr_wr;
      invalidate_q <= cmd_inval;
      flush_q      <= cmd_flush;
      miss_exc_q   <= miss_capture;

      case (state)
        IDLE: begin
          if (cmd_flush) begin
            state     <= FLUSH_WAIT;
            flush_cnt <= CNT_INIT;
          end
        end
        FLUSH_WAIT: begin
          if (flush_cnt == '0) state <= IDLE;
          else                 flush_cnt <= flush_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (vaddr_wr) tlbvaddr_q <= bus.csr_write_data & PAGE_MASK;
      if (paddr_wr) tlbpaddr_q <= bus.csr_write_data & PAGE_MASK;

      if (ctrl_wr) begin
        enable_q <= bus.csr_write_data[4];
        if (bus.csr_write_data[8]) dropped_q <= 1'b0;
      end
      if (wr_drop) dropped_q <= 1'b1;

      // A new capture outranks a clearing command in the same cycle.
      if (miss_capture) begin
        badvaddr_q     <= bus.address_x;
        miss_pending_q <= 1'b1;
      end else if (paddr_wr || cmd_inval || cmd_flush) begin
        miss_pending_q <= 1'b0;
      end
    end
  end

`ifdef LM32_DTLB_MISS_COUNTER_EN
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_cnt_q <= '0;
    end else if (wr_accept && (bus.csr_sel == SEL_MISSCNT)) begin
      miss_cnt_q <= '0;
    end else if (miss_seen && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign miss_cnt_rd = miss_cnt_q;
`else
  assign miss_cnt_rd = '0;
`endif

  always_comb begin
    bus.csr_read_data = '0;
    case (bus.csr_sel)
      SEL_VADDR:   bus.csr_read_data = tlbvaddr_q;
      SEL_PADDR:   bus.csr_read_data = tlbpaddr_q;
      SEL_BADADDR: bus.csr_read_data = badvaddr_q;
      SEL_CTRL: begin
        bus.csr_read_data[4]  = enable_q;
        bus.csr_read_data[8]  = dropped_q;
        bus.csr_read_data[9]  = miss_pending_q;
        bus.csr_read_data[10] = (state == FLUSH_WAIT);
      end
      SEL_MISSCNT: bus.csr_read_data = miss_cnt_rd;
      default:     bus.csr_read_data = '0;
    endcase
  end

  assign bus.tlbvaddr       = tlbvaddr_q;
  assign bus.tlbpaddr       = tlbpaddr_q;
  assign bus.update         = update_q;
  assign bus.invalidate     = invalidate_q;
  assign bus.flush          = flush_q;
  assign bus.dtlb_enable    = enable_q;
  assign bus.busy           = (state == FLUSH_WAIT);
  assign bus.miss_exception = miss_exc_q;
  assign bus.fsm_state      = (state == FLUSH_WAIT);

endmodule

// File: tb/tb_lm32_dtlb_ctrl.sv
// Self-checking bench for lm32_dtlb_ctrl with a small flush depth (entries=16).
module tb_lm32_dtlb_ctrl;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lm32_dtlb_ctrl_if bus();

  lm32_dtlb_ctrl #(.entries(ENTRIES), .page_size(4096)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] got;
  logic [31:0] rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] sel, input logic [31:0] data);
    bus.csr_sel          = sel;
    bus.csr_write_data   = data;
    bus.csr_write_enable = 1'b1;
    tick();
    bus.csr_write_enable = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] sel, output logic [31:0] data);
    bus.csr_sel = sel;
    #1;
    data = bus.csr_read_data;
  endtask

  task automatic count_release_busy(input string name);
    int n;
    n = 0;
    exp_q.push_back(32'(ENTRIES));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (!bus.busy) break;
      n++;
    end
    exp = exp_q.pop_front(); got = 32'(n); checks++;
    if (got !== exp) $display("FAIL %s: busy cycles got %0d expected %0d", name, got, exp); else passes++;
  endtask

  task automatic test_reset();
    bus.csr_sel = 3'd0; bus.csr_write_enable = 1'b0; bus.csr_write_data = '0;
    bus.miss_x = 1'b0; bus.address_x = '0; bus.stall_x = 1'b0;
    rst = 1'b1;
    tick(); tick();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h0000_0400);
    exp = exp_q.pop_front(); got = {30'd0, bus.busy, bus.fsm_state} == 32'd3 ? 32'd1 : 32'd0; checks++;
    if (got !== exp) $display("FAIL reset_busy: got %h expected %h", got, exp); else passes++;
    exp = exp_q.pop_front();
    got = (bus.tlbvaddr | bus.tlbpaddr) |
          {27'd0, bus.update, bus.invalidate, bus.flush, bus.dtlb_enable, bus.miss_exception};
    checks++;
    if (got !== exp) $display("FAIL reset_outputs: got %h expected %h", got, exp); else passes++;
    csr_read(3'd3, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL reset_ctrl: got %h expected %h", rd, exp); else passes++;
    count_release_busy("reset_window");
    exp_q.push_back(32'd0);
    csr_read(3'd2, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL reset_badvaddr: got %h expected %h", rd, exp); else passes++;
  endtask

  task automatic test_update();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h1234_5000);
    exp_q.push_back(32'h8000_1000);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h1234_5000);
    csr_write(3'd0, 32'h1234_5ABC);
    exp = exp_q.pop_front(); got = 32'(bus.update); checks++;
    if (got !== exp) $display("FAIL vaddr_no_update: got %h expected %h", got, exp); else passes++;
    csr_write(3'd1, 32'h8000_1FFF);
    exp = exp_q.pop_front(); got = 32'(bus.update); checks++;
    if (got !== exp) $display("FAIL update_strobe: got %h expected %h", got, exp); else passes++;
    exp = exp_q.pop_front(); got = bus.tlbvaddr; checks++;
    if (got !== exp) $display("FAIL tlbvaddr: got %h expected %h", got, exp); else passes++;
    exp = exp_q.pop_front(); got = bus.tlbpaddr; checks++;
    if (got !== exp) $display("FAIL tlbpaddr: got %h expected %h", got, exp); else passes++;
    tick();
    exp = exp_q.pop_front(); got = 32'(bus.update); checks++;
    if (got !== exp) $display("FAIL update_one_cycle: got %h expected %h", got, exp); else passes++;
    csr_read(3'd0, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL vaddr_readback: got %h expected %h", rd, exp); else passes++;
  endtask

  task automatic test_flush();
    int n;
    exp_q.push_back(32'b111);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'(ENTRIES + 1));
    exp_q.push_back(32'h8000_1000);
    exp_q.push_back(32'h0000_0110);
    exp_q.push_back(32'h0000_0010);
    csr_write(3'd3, 32'h0000_0011);
    exp = exp_q.pop_front(); got = {29'd0, bus.flush, bus.dtlb_enable, bus.busy}; checks++;
    if (got !== exp) $display("FAIL flush_cmd: got %h expected %h", got, exp); else passes++;
    n = bus.busy ? 1 : 0;
    csr_write(3'd1, 32'hDEAD_0000);
    exp = exp_q.pop_front(); got = {30'd0, bus.update, bus.flush}; checks++;
    if (got !== exp) $display("FAIL dropped_write_strobes: got %h expected %h", got, exp); else passes++;
    if (bus.busy) n++;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (!bus.busy) break;
      n++;
    end
    exp = exp_q.pop_front(); got = 32'(n); checks++;
    if (got !== exp) $display("FAIL flush_busy_cycles: got %0d expected %0d", got, exp); else passes++;
    exp = exp_q.pop_front(); got = bus.tlbpaddr; checks++;
    if (got !== exp) $display("FAIL dropped_paddr: got %h expected %h", got, exp); else passes++;
    csr_read(3'd3, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL dropped_flag: got %h expected %h", rd, exp); else passes++;
    csr_write(3'd3, 32'h0000_0110);
    csr_read(3'd3, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL dropped_clear: got %h expected %h", rd, exp); else passes++;
  endtask

  task automatic test_miss();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h0000_0210);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hC000_0404);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hC000_0404);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h0000_0010);
    bus.miss_x = 1'b1; bus.address_x = 32'hC000_0404; bus.stall_x = 1'b0;
    tick();
    bus.miss_x = 1'b0;
    exp = exp_q.pop_front(); got = 32'(bus.miss_exception); checks++;
    if (got !== exp) $display("FAIL miss_exception: got %h expected %h", got, exp); else passes++;
    csr_read(3'd3, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL miss_pending_set: got %h expected %h", rd, exp); else passes++;
    tick();
    exp = exp_q.pop_front(); got = 32'(bus.miss_exception); checks++;
    if (got !== exp) $display("FAIL miss_exception_one_cycle: got %h expected %h", got, exp); else passes++;
    csr_read(3'd2, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL badvaddr: got %h expected %h", rd, exp); else passes++;
    bus.miss_x = 1'b1; bus.address_x = 32'hC000_1000;
    tick();
    bus.miss_x = 1'b0;
    exp = exp_q.pop_front(); got = 32'(bus.miss_exception); checks++;
    if (got !== exp) $display("FAIL pending_miss_exception: got %h expected %h", got, exp); else passes++;
    tick();
    csr_read(3'd2, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL badvaddr_held: got %h expected %h", rd, exp); else passes++;
    csr_write(3'd3, 32'h0000_0012);
    exp = exp_q.pop_front(); got = 32'(bus.invalidate); checks++;
    if (got !== exp) $display("FAIL invalidate_strobe: got %h expected %h", got, exp); else passes++;
    csr_read(3'd3, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL invalidate_clears_pending: got %h expected %h", rd, exp); else passes++;
    tick();
  endtask

  task automatic test_stall();
    int n;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'hB000_2000);
    exp_q.push_back(32'h0000_0010);
    n = 0;
    bus.miss_x = 1'b1; bus.stall_x = 1'b1; bus.address_x = 32'hA000_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.miss_exception) n++;
    end
    bus.stall_x = 1'b0; bus.address_x = 32'hB000_2000;
    tick();
    bus.miss_x = 1'b0;
    if (bus.miss_exception) n++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.miss_exception) n++;
    end
    exp = exp_q.pop_front(); got = 32'(n); checks++;
    if (got !== exp) $display("FAIL stall_capture_count: got %0d expected %0d", got, exp); else passes++;
    csr_read(3'd2, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL stall_badvaddr: got %h expected %h", rd, exp); else passes++;
    csr_write(3'd1, 32'h0000_2FFF);
    csr_read(3'd3, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL update_clears_pending: got %h expected %h", rd, exp); else passes++;
  endtask

  task automatic test_miss_counter();
`ifdef LM32_DTLB_MISS_COUNTER_EN
    exp_q.push_back(32'd5);
`else
    exp_q.push_back(32'd0);
`endif
    exp_q.push_back(32'd0);
    csr_write(3'd4, 32'h0);
    for (int i = 0; i < 7; i++) begin
      bus.miss_x    = 1'b1;
      bus.stall_x   = (i == 2 || i == 4);
      bus.address_x = 32'($urandom_range(0, 32'h7FFF_FFFF));
      tick();
    end
    bus.miss_x = 1'b0; bus.stall_x = 1'b0;
    csr_read(3'd4, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL miss_count: got %h expected %h", rd, exp); else passes++;
    csr_write(3'd4, 32'h0);
    csr_read(3'd4, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL miss_count_clear: got %h expected %h", rd, exp); else passes++;
  endtask

  task automatic test_reset_mid_flush();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h0000_0400);
    exp_q.push_back(32'd0);
    csr_write(3'd3, 32'h0000_0011);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    exp = exp_q.pop_front(); got = 32'(bus.busy); checks++;
    if (got !== exp) $display("FAIL midflush_reset_busy: got %h expected %h", got, exp); else passes++;
    csr_read(3'd3, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) $display("FAIL midflush_reset_ctrl: got %h expected %h", rd, exp); else passes++;
    exp = exp_q.pop_front(); got = bus.tlbvaddr | bus.tlbpaddr; checks++;
    if (got !== exp) $display("FAIL midflush_reset_addrs: got %h expected %h", got, exp); else passes++;
    tick();
    count_release_busy("midflush_reset_window");
  endtask

  initial begin
    test_reset();
    test_update();
    test_flush();
    test_miss();
    test_stall();
    test_miss_counter();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
